// File: rtl/sv_dsp_pkg.sv
// Shared DSP definitions: window FSM encoding, accumulator width and the
// round-half-up arithmetic shift used by the mean extraction and mean removal stages.
package sv_dsp_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_FILL  = 2'd1,
      ST_RUN   = 2'd2
   } dsp_state_e;

   // Widest accumulator any caller may pass in (64-bit samples, 1024-deep window).
   localparam int MAX_ACC_W = 74;

   function automatic int acc_w(input int q_in, input int log2_m);
      return q_in + log2_m;
   endfunction

   // (v + 2**(sh-1)) >>> sh; the caller sign-extends into, and truncates out of, MAX_ACC_W.
   function automatic logic signed [MAX_ACC_W-1:0] round_half_up_shift(
      input logic signed [MAX_ACC_W-1:0] v,
      input int unsigned                 sh
   );
      logic signed [MAX_ACC_W-1:0] half;
      half = MAX_ACC_W'(1) << (sh - 1);
      return (v + half) >>> sh;
   endfunction

endpackage

// File: rtl/window_ram_sp.sv
// M x Q_in window store: one synchronous write port, one asynchronous read port.
module window_ram_sp #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   always_ff @(posedge clock) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/moving_mean_extractor_pipelined.sv
// Sliding-window running mean of the last 2**LOG2_M samples, three-stage pipeline,
// with a CLEAR/FILL/RUN control FSM.
module moving_mean_extractor_pipelined
   import sv_dsp_pkg::*;
#(
   parameter int LOG2_M = 5,
   parameter int Q_in   = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   restart,
   input  logic signed [Q_in-1:0] data_in,
   input  logic                   data_in_valid,
   output logic signed [Q_in-1:0] data_out,
   output logic                   data_out_valid,
   output logic                   window_full,
   output logic                   busy,
   output dsp_state_e             state_dbg
);

   localparam int M     = 2**LOG2_M;
   localparam int ACC_W = acc_w(Q_in, LOG2_M);
   localparam logic [LOG2_M-1:0] ADDR_LAST = LOG2_M'(M - 1);

   dsp_state_e               state_q, state_d;
   logic [LOG2_M-1:0]        clr_addr_q, clr_addr_d;
   logic [LOG2_M-1:0]        idx_q, idx_d;
   logic [LOG2_M-1:0]        fill_cnt_q, fill_cnt_d;
   logic                     s1_valid_q, s1_valid_d;
   logic                     s1_emit_q, s1_emit_d;
   logic signed [Q_in-1:0]   s1_data_q, s1_data_d;
   logic signed [Q_in-1:0]   s1_old_q, s1_old_d;
   logic [LOG2_M-1:0]        s1_idx_q, s1_idx_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic                     s2_valid_q, s2_valid_d;
   logic signed [Q_in-1:0]   dout_q, dout_d;
   logic                     dout_valid_q, dout_valid_d;

   logic                     accept;
   logic                     ram_we;
   logic [LOG2_M-1:0]        ram_waddr;
   logic [Q_in-1:0]          ram_wdata;
   logic [Q_in-1:0]          ram_rdata;

   // Handshake: data_in is taken on any clock with data_in_valid high, restart low and the
   // FSM out of CLEAR; there is no ready, and data_out_valid is a one-cycle, unstallable strobe.
   assign accept = data_in_valid && !restart && (state_q != ST_CLEAR);

   assign ram_we    = (state_q == ST_CLEAR) || s1_valid_q;
   assign ram_waddr = (state_q == ST_CLEAR) ? clr_addr_q : s1_idx_q;
   assign ram_wdata = (state_q == ST_CLEAR) ? '0 : s1_data_q;

   window_ram_sp #(
      .ADDR_W (LOG2_M),
      .DATA_W (Q_in)
   ) u_ram (
      .clock   (clock),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .raddr_i (idx_q),
      .rdata_o (ram_rdata)
   );

   always_comb begin
      state_d      = state_q;
      clr_addr_d   = clr_addr_q;
      idx_d        = idx_q;
      fill_cnt_d   = fill_cnt_q;
      s1_valid_d   = 1'b0;
      s1_emit_d    = 1'b0;
      s1_data_d    = s1_data_q;
      s1_old_d     = s1_old_q;
      s1_idx_d     = s1_idx_q;
      acc_d        = acc_q;
      s2_valid_d   = 1'b0;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;

      case (state_q)
         ST_CLEAR: begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == ADDR_LAST) state_d = ST_FILL;
         end
         ST_FILL: begin
            if (accept) begin
               fill_cnt_d = fill_cnt_q + 1'b1;
               if (fill_cnt_q == ADDR_LAST) state_d = ST_RUN;
            end
         end
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_CLEAR;
      endcase

      // S1: capture sample and the value it evicts from the window.
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_emit_d  = (state_q == ST_RUN) || (fill_cnt_q == ADDR_LAST);
         s1_data_d  = data_in;
         s1_old_d   = signed'(ram_rdata);
         s1_idx_d   = idx_q;
         idx_d      = idx_q + 1'b1;
      end

      // S2: write back and update the running sum.
      if (s1_valid_q) begin
         acc_d      = acc_q + ACC_W'(s1_data_q) - ACC_W'(s1_old_q);
         s2_valid_d = s1_emit_q;
      end

      // S3: scale the sum to a mean.
      if (s2_valid_q) begin
         dout_d       = Q_in'(round_half_up_shift(MAX_ACC_W'(acc_q), LOG2_M));
         dout_valid_d = 1'b1;
      end

      if (restart) begin
         state_d      = ST_CLEAR;
         clr_addr_d   = '0;
         idx_d        = '0;
         fill_cnt_d   = '0;
         acc_d        = '0;
         s1_valid_d   = 1'b0;
         s2_valid_d   = 1'b0;
         dout_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_CLEAR;
         clr_addr_q   <= '0;
         idx_q        <= '0;
         fill_cnt_q   <= '0;
         s1_valid_q   <= 1'b0;
         s1_emit_q    <= 1'b0;
         s1_data_q    <= '0;
         s1_old_q     <= '0;
         s1_idx_q     <= '0;
         acc_q        <= '0;
         s2_valid_q   <= 1'b0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_addr_q   <= clr_addr_d;
         idx_q        <= idx_d;
         fill_cnt_q   <= fill_cnt_d;
         s1_valid_q   <= s1_valid_d;
         s1_emit_q    <= s1_emit_d;
         s1_data_q    <= s1_data_d;
         s1_old_q     <= s1_old_d;
         s1_idx_q     <= s1_idx_d;
         acc_q        <= acc_d;
         s2_valid_q   <= s2_valid_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   assign data_out       = dout_q;
   assign data_out_valid = dout_valid_q;
   assign window_full    = (state_q == ST_RUN);
   assign busy           = (state_q == ST_CLEAR);
   assign state_dbg      = state_q;

endmodule

// File: tb/tb_moving_mean_extractor_pipelined.sv
// Directed and gap-randomised bench for the moving mean extractor with a queued scoreboard.
`timescale 1ns/1ps
module tb_moving_mean_extractor_pipelined;
   import sv_dsp_pkg::*;

   localparam int LOG2_M = 5;
   localparam int Q_IN   = 32;
   localparam int M      = 32;

   logic                   clock = 1'b0;
   logic                   reset = 1'b0;
   logic                   restart = 1'b0;
   logic                   data_in_valid = 1'b0;
   logic signed [Q_IN-1:0] data_in = '0;
   logic signed [Q_IN-1:0] data_out;
   logic                   data_out_valid;
   logic                   window_full;
   logic                   busy;
   dsp_state_e             state_dbg;

   int cyc = 0;
   int n_cmp = 0;
   int n_err = 0;

   logic [Q_IN-1:0] exp_q[$];
   int              due_q[$];
   longint          win_q[$];
   int              mdl_cnt = 0;

   logic signed [Q_IN-1:0] mon_e;
   int                     mon_d;

   moving_mean_extractor_pipelined #(
      .LOG2_M (LOG2_M),
      .Q_in   (Q_IN)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .restart        (restart),
      .data_in        (data_in),
      .data_in_valid  (data_in_valid),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .window_full    (window_full),
      .busy           (busy),
      .state_dbg      (state_dbg)
   );

   // clock / cycle counter
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // golden mean: floor((sum + M/2) / M)
   function automatic longint model_mean();
      longint s;
      longint q;
      s = 0;
      foreach (win_q[i]) s += win_q[i];
      s += M / 2;
      q = s / M;
      if ((s % M != 0) && (s < 0)) q -= 1;
      return q;
   endfunction

   // driver tasks
   task automatic send(input longint v);
      longint m;
      data_in       = v[Q_IN-1:0];
      data_in_valid = 1'b1;
      win_q.push_back(v);
      if (win_q.size() > M) void'(win_q.pop_front());
      mdl_cnt++;
      if (mdl_cnt >= M) begin
         m = model_mean();
         exp_q.push_back(m[Q_IN-1:0]);
         due_q.push_back(cyc + 3);
      end
      @(negedge clock);
      data_in_valid = 1'b0;
      check("window_full", window_full, (mdl_cnt >= M) ? 1 : 0);
   endtask

   task automatic send_n(input int n, input longint v);
      for (int i = 0; i < n; i++) send(v);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic wait_clear();
      int hi;
      hi = 0;
      for (int i = 0; i < M; i++) begin
         if (busy) hi++;
         data_in       = $urandom;
         data_in_valid = 1'b1;
         @(negedge clock);
      end
      data_in_valid = 1'b0;
      check("busy_cycles", hi, M);
      check("busy_end", busy, 0);
   endtask

   task automatic do_restart(input bit with_valid);
      restart = 1'b1;
      if (with_valid) begin
         data_in       = 777;
         data_in_valid = 1'b1;
      end
      while (due_q.size() > 0 && due_q[$] >= cyc + 1) begin
         void'(due_q.pop_back());
         void'(exp_q.pop_back());
      end
      win_q.delete();
      mdl_cnt = 0;
      @(negedge clock);
      restart       = 1'b0;
      data_in_valid = 1'b0;
      check("restart_window_full", window_full, 0);
      wait_clear();
   endtask

   task automatic async_reset_mid();
      @(negedge clock);
      #2;
      reset         = 1'b0;
      data_in_valid = 1'b0;
      exp_q.delete();
      due_q.delete();
      win_q.delete();
      mdl_cnt = 0;
      #1;
      check("arst_data_out", data_out, 0);
      check("arst_valid", data_out_valid, 0);
      check("arst_window_full", window_full, 0);
      check("arst_busy", busy, 1);
      @(negedge clock);
      reset = 1'b1;
      wait_clear();
   endtask

   // scoreboard monitor
   always @(negedge clock) begin
      if (reset) begin
         while (due_q.size() > 0 && due_q[0] < cyc) begin
            n_cmp++;
            n_err++;
            $display("FAIL missing_output: got none, expected %0d at cycle %0d", $signed(exp_q[0]), due_q[0]);
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
         end
         if (data_out_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_output: got %0d, expected no output (cycle %0d)", data_out, cyc);
            end else begin
               mon_e = exp_q.pop_front();
               mon_d = due_q.pop_front();
               check("data_out", data_out, mon_e);
               check("latency_cycle", cyc, mon_d);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      longint v;
      // reset state
      #1;
      check("rst_data_out", data_out, 0);
      check("rst_valid", data_out_valid, 0);
      check("rst_window_full", window_full, 0);
      check("rst_busy", busy, 1);
      check("rst_state", state_dbg, ST_CLEAR);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      // 1: clear duration, strobes ignored
      wait_clear();

      // 2: constant +100
      send_n(36, 100);
      idle(4);
      check("const_100", data_out, 100);

      // 3: zeros then step to +64
      do_restart(1'b0);
      send_n(32, 0);
      send_n(40, 64);
      idle(4);
      check("step_64", data_out, 64);

      // 4: constant -3 and rounding windows
      send_n(32, -3);
      idle(4);
      check("const_m3", data_out, -3);
      send_n(16, -5);
      send_n(16, 0);
      idle(4);
      check("round_m80", data_out, -2);
      send_n(16, 1);
      send_n(16, 0);
      idle(4);
      check("round_p16", data_out, 1);

      // 5: restart coincident with a valid while in RUN
      send_n(5, 10);
      do_restart(1'b1);
      send_n(34, 7);
      idle(4);
      check("refill_7", data_out, 7);

      // 6: random gaps and data with an async reset mid-stream
      for (int k = 0; k < 90; k++) begin
         idle($urandom_range(0, 5));
         if (k == 45) async_reset_mid();
         v = longint'($signed($urandom));
         send(v);
      end

      idle(8);
      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
